outq_ctrl: RTL
==============

Name: outq_ctrl

Overview:
- Memory-mapped output-queue controller between the CPU data bus and the character-output sink.
- Buffers CPU word stores in a FIFO and drains them to the sink one character at a time over a valid/ready handshake, with a programmable inter-character gap.
- Exposes status, emitted-count and control registers so firmware can poll for space instead of overrunning the sink.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- PACE, 4, idle cycles inserted after each accepted character; ≥1.
- CNT_W, 32, width of the emitted-character counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sel  in  1  address decode hit for this block, from the top level
- daddr  in  32  byte address; only bits [3:2] are used
- dwdata  in  32  store data
- dwe  in  4  byte write enables; only 4'b1111 is a valid write
- drdata  out  32  read data, combinational from daddr[3:2]
- out_valid  out  1  character available to the sink
- out_data  out  8  character to the sink
- out_ready  in  1  sink accepts the character this cycle

Behaviour:
- Register map (daddr[3:2]):
  - 0 DATA: write pushes dwdata[7:0]; read returns 0.
  - 1 STATUS: read {16'b0, occupancy[7:0], 4'b0, ovf, busy, empty, full}; any write clears ovf.
  - 2 COUNT: read returns the emitted-character count; any write clears it to 0.
  - 3 CTRL: bit0 = drain enable; read returns {31'b0, en}.
- Writes take effect only when sel && dwe==4'b1111. Partial byte enables are ignored.
- Reset values:
  - FIFO empty, occupancy 0, COUNT 0, ovf 0, en 1.
  - State IDLE, out_valid 0, out_data 0.
- FIFO:
  - Circular; read and write pointers wrap modulo DEPTH.
  - Occupancy is held in a separate register of width clog2(DEPTH)+1.
  - Push when full and no pop in the same cycle: data dropped, ovf set (sticky).
  - Push and pop in the same cycle: both occur; occupancy unchanged, including at full and at one entry.
- FSM states IDLE, SEND, GAP:
  - IDLE: if en && !empty, go to SEND next edge.
  - SEND: out_valid=1, out_data=FIFO head (stable while waiting). On out_valid && out_ready: pop, COUNT+1 (wraps at 2^CNT_W), load gap counter with PACE-1, go to GAP.
  - GAP: out_valid=0. Decrement the gap counter; at 0, go to IDLE. Exactly PACE cycles are spent in GAP.
- Clearing en while in SEND does not retract out_valid; the current character completes, then the FSM stops in IDLE.
- busy = (state != IDLE).
- Latency: a DATA write in cycle 0 to an empty FIFO with the FSM in IDLE and en=1 gives out_valid high in cycle 2.
- Throughput with out_ready held high: one character per PACE+2 cycles.
- A COUNT clear in the same cycle as a handshake: the clear wins, COUNT=0.
- Reset mid-SEND: out_valid drops the next cycle, and FIFO contents are discarded.

Decomposition:
- Package outq_pkg holds:
  - Register offset constants: REG_DATA=0, REG_STATUS=1, REG_COUNT=2, REG_CTRL=3.
  - STATUS bit positions.
  - FSM state enum {IDLE, SEND, GAP}.
- One sub-module, outq_fifo: parameterized DEPTH×8 synchronous FIFO with push/pop/full/empty/occupancy.
- The FSM, registers and read mux live in outq_ctrl.

Test Plan:
- Reset, then read all four registers → STATUS=0x00000002, COUNT=0, CTRL=1, out_valid=0.
- out_ready=1; write 'H','i' to DATA on consecutive cycles → sink receives 0x48 then 0x69, handshakes PACE+2=6 cycles apart; COUNT=2; STATUS empty=1, busy=0.
- CTRL=0; write 9 chars with DEPTH=8 → STATUS full=1, ovf=1, occupancy=8; write STATUS → ovf=0; set CTRL=1 → 8 chars emitted in order, 9th absent.
- out_ready=0 for 20 cycles with 'A' queued → out_valid stays 1 and out_data stays 0x41; COUNT unchanged until out_ready rises.
- Write with dwe=4'b0011 or sel=0 → no push, occupancy 0; write COUNT in the same cycle as a handshake → COUNT=0.
- Assert reset during SEND with 3 entries queued → the next cycle has out_valid=0, occupancy=0, COUNT=0, CTRL=1.

Source files
------------

// File: rtl/outq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : outq_pkg
//  Description : Shared definitions for the output-queue controller.
//                Holds the register offsets (daddr[3:2]), the STATUS bit
//                positions and the drain FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package outq_pkg;

    // Register offsets, decoded from daddr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_OCC_LSB = 8;   // occupancy occupies [15:8]

    // Drain FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/outq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : outq_fifo
//  Description : DEPTH x 8 circular synchronous FIFO. Pointers wrap modulo
//                DEPTH; occupancy is kept in its own register so full and
//                empty are unambiguous. A push while full is accepted only
//                when a pop happens in the same cycle (the pop frees the slot).
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                i_push      - write i_wdata at the tail
//                i_pop       - drop the head entry
//                i_wdata     - data to push
//                o_rdata     - current head entry (combinational)
//                o_full      - occupancy == DEPTH
//                o_empty     - occupancy == 0
//                o_count     - occupancy, clog2(DEPTH)+1 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module outq_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_wdata,
    output logic [7:0]                 o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // At full the slot being popped is the one the push lands in.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/outq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : outq_ctrl
//  Description : Memory-mapped output-queue controller. CPU word stores to
//                DATA are queued in a FIFO and drained one character at a
//                time to the sink over valid/ready, followed by PACE idle
//                cycles. STATUS/COUNT/CTRL let firmware poll for space.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                sel         - address decode hit for this block
//                daddr       - byte address, bits [3:2] select the register
//                dwdata      - store data
//                dwe         - byte enables, only 4'b1111 writes
//                drdata      - read data (combinational from daddr[3:2])
//                out_valid   - character available to the sink
//                out_data    - character to the sink
//                out_ready   - sink accepts the character this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module outq_ctrl
    import outq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PACE  = 4,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OW    = AW + 1;
    localparam int GAP_W = (PACE > 1) ? $clog2(PACE) : 1;

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_wr_data;
    logic w_wr_status;
    logic w_wr_count;
    logic w_wr_ctrl;

    assign w_wr        = sel && (dwe == 4'b1111);
    assign w_wr_data   = w_wr && (daddr[3:2] == REG_DATA);
    assign w_wr_status = w_wr && (daddr[3:2] == REG_STATUS);
    assign w_wr_count  = w_wr && (daddr[3:2] == REG_COUNT);
    assign w_wr_ctrl   = w_wr && (daddr[3:2] == REG_CTRL);

    // Address and data bits outside the decoded fields are don't-care.
    logic w_unused;
    assign w_unused = ^{daddr[31:4], daddr[1:0], dwdata[31:8]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    w_fifo_rdata;
    logic          w_full;
    logic          w_empty;
    logic [OW-1:0] w_occ;
    logic          w_push;
    logic          w_pop;
    logic          w_handshake;

    state_t            r_state;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic [GAP_W-1:0]  r_gap;
    logic              r_en;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_count;

    // out_valid is only ever high in SEND, so this is the SEND handshake.
    assign w_handshake = r_out_valid && out_ready;
    assign w_push      = w_wr_data;
    assign w_pop       = w_handshake;

    outq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (dwdata[7:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    // ------------------------------------------------------------------
    // Drain FSM with registered sink outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_gap       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The head is captured on entry; it cannot change while
                    // in SEND because only SEND pops.
                    if (r_en && !w_empty) begin
                        r_state     <= SEND;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_fifo_rdata;
                    end
                end
                SEND: begin
                    // en is deliberately ignored here: an offered character
                    // is never retracted.
                    if (out_ready) begin
                        r_state     <= GAP;
                        r_out_valid <= 1'b0;
                        r_gap       <= GAP_W'(PACE - 1);
                    end
                end
                GAP: begin
                    if (r_gap == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en    <= 1'b1;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= dwdata[0];
            end

            if (w_wr_status) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end

            // A clear coinciding with a handshake leaves the count at zero.
            if (w_wr_count) begin
                r_count <= '0;
            end else if (w_handshake) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [7:0]  w_occ8;
    logic [31:0] w_status;
    logic [31:0] w_count32;

    always_comb begin
        w_occ8         = '0;
        w_occ8[OW-1:0] = w_occ;

        w_status                          = '0;
        w_status[STAT_FULL]               = w_full;
        w_status[STAT_EMPTY]              = w_empty;
        w_status[STAT_BUSY]               = (r_state != IDLE);
        w_status[STAT_OVF]                = r_ovf;
        w_status[STAT_OCC_LSB +: 8]       = w_occ8;

        w_count32              = '0;
        w_count32[CNT_W-1:0]   = r_count;
    end

    always_comb begin
        drdata = '0;
        case (daddr[3:2])
            REG_DATA:   drdata = '0;
            REG_STATUS: drdata = w_status;
            REG_COUNT:  drdata = w_count32;
            REG_CTRL:   drdata = {31'b0, r_en};
            default:    drdata = '0;
        endcase
    end

endmodule
`default_nettype wire
